apb3_memory_completer: RTL and testbench

Synthesizable APB3 completer: a word-addressed memory plus read-only transfer statistics. It sits directly downstream of `apb3_requester_synth` and terminates that requester's single and back-to-back transfers in hardware. This lets the requester pattern be checked without Renode, or alongside it via the interface mux. It inserts a configurable number of wait states and flags bad accesses with PSLVERR.

---
 rtl/apb3_completer_pkg.sv | 20 ++
 rtl/renode_apb3_if.sv | 24 ++
 rtl/apb3_completer_decode.sv | 42 ++++
 rtl/apb3_memory_completer.sv | 190 +++++++++++++++++++
 tb/tb_apb3_memory_completer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb3_completer_pkg.sv
// rtl/apb3_completer_pkg.sv - shared types and constants for the APB3 memory completer
package apb3_completer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } completer_state_e;

    typedef enum logic [1:0] {
        MEM = 2'd0,
        CNT = 2'd1,
        ERR = 2'd2
    } decode_e;

    // Counter word indices, relative to Depth
    localparam int unsigned WrCntOffset  = 0;
    localparam int unsigned RdCntOffset  = 1;
    localparam int unsigned ErrCntOffset = 2;

endpackage

// File: rtl/renode_apb3_if.sv
// rtl/renode_apb3_if.sv - APB3 bus bundle with requester and completer views
interface renode_apb3_if #(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DataWidth    = 32
);
    logic [AddressWidth-1:0] paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic                    pready;
    logic [DataWidth-1:0]    prdata;
    logic                    pslverr;

    modport requester (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport completer (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb3_completer_decode.sv
// rtl/apb3_completer_decode.sv - address decode with alignment and range checks
module apb3_completer_decode
    import apb3_completer_pkg::*;
#(
    parameter int unsigned             AddressWidth = 32,
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             Depth        = 16,
    parameter logic [AddressWidth-1:0] BaseAddress  = '0,
    localparam int unsigned            IdxW         = $clog2(Depth)
) (
    input  logic [AddressWidth-1:0] addr,
    input  logic                    write,
    output decode_e                 kind,
    output logic [IdxW-1:0]         idx,
    output logic [1:0]              cnt_sel
);
    localparam int unsigned             ByteBits  = $clog2(DataWidth / 8);
    localparam logic [AddressWidth-1:0] AlignMask = AddressWidth'((DataWidth / 8) - 1);
    localparam logic [AddressWidth-1:0] DepthA    = AddressWidth'(Depth);
    localparam logic [AddressWidth-1:0] LastCnt   = AddressWidth'(ErrCntOffset);

    logic [AddressWidth-1:0] off;
    logic [AddressWidth-1:0] word;
    logic [AddressWidth-1:0] cnt_word;

    // Classify the byte address; counters are read-only so a write to one is an error
    always_comb begin
        off      = addr - BaseAddress;
        word     = off >> ByteBits;
        cnt_word = word - DepthA;
        idx      = word[IdxW-1:0];
        cnt_sel  = cnt_word[1:0];
        kind     = ERR;
        if ((addr >= BaseAddress) && ((off & AlignMask) == '0)) begin
            if (word < DepthA) begin
                kind = MEM;
            end else if (!write && (cnt_word <= LastCnt)) begin
                kind = CNT;
            end
        end
    end
endmodule

// File: rtl/apb3_memory_completer.sv
// rtl/apb3_memory_completer.sv - APB3 completer: word memory, transfer counters, wait states
module apb3_memory_completer
    import apb3_completer_pkg::*;
#(
    parameter int unsigned             AddressWidth = 32,
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             Depth        = 16,
    parameter logic [AddressWidth-1:0] BaseAddress  = '0,
    parameter int unsigned             WaitStates   = 1
) (
    input  logic              pclk,
    input  logic              presetn,
    renode_apb3_if.completer  apb
);
    localparam int unsigned IdxW     = $clog2(Depth);
    localparam logic [3:0]  WaitInit = 4'(WaitStates);

    typedef logic [DataWidth-1:0] word_t;

    completer_state_e        state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                    write_q, write_d;
    word_t                   wdata_q, wdata_d;
    logic                    pready_q, pready_d;
    word_t                   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    word_t                   mem_q [Depth];
    word_t                   mem_d [Depth];
    word_t                   wrcnt_q, wrcnt_d;
    word_t                   rdcnt_q, rdcnt_d;
    word_t                   errcnt_q, errcnt_d;

    logic [AddressWidth-1:0] dec_addr;
    logic                    dec_write;
    decode_e                 dec_kind;
    logic [IdxW-1:0]         dec_idx;
    logic [1:0]              dec_cnt_sel;
    word_t                   rd_value;
    logic                    respond;

    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + word_t'(1);
    endfunction

    // Decode the live bus during setup (needed for zero wait states), the latched copy afterwards
    always_comb begin
        dec_addr  = (state_q == IDLE) ? apb.paddr  : addr_q;
        dec_write = (state_q == IDLE) ? apb.pwrite : write_q;
    end

    apb3_completer_decode #(
        .AddressWidth (AddressWidth),
        .DataWidth    (DataWidth),
        .Depth        (Depth),
        .BaseAddress  (BaseAddress)
    ) u_decode (
        .addr    (dec_addr),
        .write   (dec_write),
        .kind    (dec_kind),
        .idx     (dec_idx),
        .cnt_sel (dec_cnt_sel)
    );

    // Read value for the decoded target; counters show their value before this transfer
    always_comb begin
        rd_value = '0;
        case (dec_kind)
            MEM: rd_value = mem_q[dec_idx];
            CNT: begin
                case (dec_cnt_sel)
                    2'(WrCntOffset):  rd_value = wrcnt_q;
                    2'(RdCntOffset):  rd_value = rdcnt_q;
                    2'(ErrCntOffset): rd_value = errcnt_q;
                    default:          rd_value = '0;
                endcase
            end
            default: rd_value = '0;
        endcase
    end

    // Transfer FSM, wait-state countdown, response generation and commit
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        mem_d     = mem_q;
        wrcnt_d   = wrcnt_q;
        rdcnt_d   = rdcnt_q;
        errcnt_d  = errcnt_q;
        respond   = 1'b0;

        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = ACCESS;
                    addr_d  = apb.paddr;
                    write_d = apb.pwrite;
                    wdata_d = apb.pwdata;
                    wait_d  = WaitInit;
                    respond = (WaitInit == 4'd0);
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    state_d   = IDLE;
                    wait_d    = '0;
                    pready_d  = 1'b0;
                    prdata_d  = '0;
                    pslverr_d = 1'b0;
                end else if (pready_q) begin
                    if (apb.penable) begin
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        prdata_d  = '0;
                        pslverr_d = 1'b0;
                        case (dec_kind)
                            MEM: begin
                                if (write_q) begin
                                    mem_d[dec_idx] = wdata_q;
                                    wrcnt_d        = sat_inc(wrcnt_q);
                                end else begin
                                    rdcnt_d = sat_inc(rdcnt_q);
                                end
                            end
                            ERR:     errcnt_d = sat_inc(errcnt_q);
                            default: ;
                        endcase
                    end
                end else if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    respond = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (respond) begin
            pready_d  = 1'b1;
            pslverr_d = (dec_kind == ERR);
            prdata_d  = dec_write ? '0 : rd_value;
        end
    end

    // State, response and storage registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wrcnt_q   <= '0;
            rdcnt_q   <= '0;
            errcnt_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            wrcnt_q   <= wrcnt_d;
            rdcnt_q   <= rdcnt_d;
            errcnt_q  <= errcnt_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_apb3_memory_completer.sv
// tb/tb_apb3_memory_completer.sv - directed bench for apb3_memory_completer
module tb_apb3_memory_completer;

    logic        clk;
    logic        rst_n;
    int          dsel;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int checks;
    int errors;

    renode_apb3_if #(.AddressWidth(32), .DataWidth(32)) if0 ();
    renode_apb3_if #(.AddressWidth(32), .DataWidth(32)) if1 ();
    renode_apb3_if #(.AddressWidth(32), .DataWidth(32)) if2 ();
    renode_apb3_if #(.AddressWidth(32), .DataWidth(32)) if3 ();

    assign if0.paddr = paddr;  assign if0.penable = penable;  assign if0.pwrite = pwrite;  assign if0.pwdata = pwdata;
    assign if1.paddr = paddr;  assign if1.penable = penable;  assign if1.pwrite = pwrite;  assign if1.pwdata = pwdata;
    assign if2.paddr = paddr;  assign if2.penable = penable;  assign if2.pwrite = pwrite;  assign if2.pwdata = pwdata;
    assign if3.paddr = paddr;  assign if3.penable = penable;  assign if3.pwrite = pwrite;  assign if3.pwdata = pwdata;
    assign if0.psel = psel && (dsel == 0);
    assign if1.psel = psel && (dsel == 1);
    assign if2.psel = psel && (dsel == 2);
    assign if3.psel = psel && (dsel == 3);

    apb3_memory_completer #(.WaitStates(1)) dut0 (.pclk(clk), .presetn(rst_n), .apb(if0));
    apb3_memory_completer #(.WaitStates(0)) dut1 (.pclk(clk), .presetn(rst_n), .apb(if1));
    apb3_memory_completer #(.WaitStates(3)) dut2 (.pclk(clk), .presetn(rst_n), .apb(if2));
    apb3_memory_completer #(.WaitStates(1), .BaseAddress(32'h1000)) dut3 (.pclk(clk), .presetn(rst_n), .apb(if3));

    always_comb begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        case (dsel)
            0: begin pready = if0.pready; prdata = if0.prdata; pslverr = if0.pslverr; end
            1: begin pready = if1.pready; prdata = if1.prdata; pslverr = if1.pslverr; end
            2: begin pready = if2.pready; prdata = if2.prdata; pslverr = if2.pslverr; end
            3: begin pready = if3.pready; prdata = if3.prdata; pslverr = if3.pslverr; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
    endtask

    // One transfer starting now (just after a rising edge); returns just after the completing edge
    // with psel still high so a following call forms a back-to-back transfer.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd, input bit garble,
                        output logic [31:0] rd, output logic er, output int cyc);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wd;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        if (garble) begin
            paddr  = addr ^ 32'h4;
            pwdata = ~wd;
            pwrite = ~wr;
        end
        cyc = 1;
        rd  = '0;
        er  = 1'b0;
        forever begin
            @(negedge clk);
            if (pready) break;
            if (cyc >= 40) begin
                checks++;
                errors++;
                $display("FAIL xfer_timeout: got no pready after %0d cycles expected pready", cyc);
                cyc = -1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc > 0) begin
            rd = prdata;
            er = pslverr;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          hits;

    initial begin
        checks  = 0;
        errors  = 0;
        dsel    = 0;
        paddr   = '0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = '0;
        rst_n   = 1'b0;

        vecs[0]  = '{32'h04, 1'b1, 32'hA5A5_0001, 32'h0,         1'b0};
        vecs[1]  = '{32'h04, 1'b0, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[2]  = '{32'h02, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[3]  = '{32'h50, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{32'h40, 1'b1, 32'h1111_2222, 32'h0,         1'b1};
        vecs[5]  = '{32'h04, 1'b0, 32'h0,         32'hA5A5_0001, 1'b0};
        vecs[6]  = '{32'h00, 1'b0, 32'h0,         32'h0,         1'b0};
        vecs[7]  = '{32'h48, 1'b0, 32'h0,         32'h3,         1'b0};
        vecs[8]  = '{32'h40, 1'b0, 32'h0,         32'h1,         1'b0};
        vecs[9]  = '{32'h44, 1'b0, 32'h0,         32'h3,         1'b0};
        vecs[10] = '{32'h3C, 1'b1, 32'h0000_FFFF, 32'h0,         1'b0};
        vecs[11] = '{32'h3C, 1'b0, 32'h0,         32'h0000_FFFF, 1'b0};
        vecs[12] = '{32'h4C, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[13] = '{32'h05, 1'b1, 32'h7777_7777, 32'h0,         1'b1};
        vecs[14] = '{32'h48, 1'b0, 32'h0,         32'h5,         1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_pready", {31'b0, if0.pready}, 32'h0);
        check("reset_prdata", if0.prdata, 32'h0);
        check("reset_pslverr", {31'b0, if0.pslverr}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // WaitStates=1: table of reads, writes, errors and counter reads
        dsel = 0;
        for (int i = 0; i < 15; i++) begin
            xfer(vecs[i].addr, vecs[i].write, vecs[i].wdata, 1'b0, rd, er, cyc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_cycles", i), cyc, 32'd2);
        end
        go_idle();
        @(negedge clk);
        check("pready_low_after_done", {31'b0, pready}, 32'h0);
        @(posedge clk); #1;

        // WaitStates=0: back-to-back writes then reads, two cycles each
        dsel = 1;
        for (int i = 0; i < 8; i++) begin
            xfer(32'(i * 4), 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, rd, er, cyc);
            check($sformatf("ws0_wr%0d_cycles", i), cyc, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(32'(i * 4), 1'b0, 32'h0, 1'b0, rd, er, cyc);
            check($sformatf("ws0_rd%0d_data", i), rd, 32'hC0DE_0000 + 32'(i));
            check($sformatf("ws0_rd%0d_cycles", i), cyc, 32'd1);
        end
        xfer(32'h44, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("ws0_rdcnt", rd, 32'd8);
        xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("ws0_wrcnt", rd, 32'd8);
        go_idle();

        // WaitStates=3: abort in T1, then access-phase bus changes, then penable without setup
        dsel    = 2;
        paddr   = 32'h8;
        pwrite  = 1'b1;
        pwdata  = 32'hDEAD_BEEF;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (pready) hits++;
        end
        check("abort_no_pready", hits, 32'd0);
        @(posedge clk); #1;
        xfer(32'h8, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("abort_word_zero", rd, 32'h0);
        check("ws3_cycles", cyc, 32'd4);
        xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("abort_wrcnt", rd, 32'h0);
        xfer(32'h10, 1'b1, 32'h0000_0055, 1'b1, rd, er, cyc);
        check("garble_wr_ok", {31'b0, er}, 32'h0);
        xfer(32'h10, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("garble_latched_word", rd, 32'h0000_0055);
        xfer(32'h14, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("garble_other_word", rd, 32'h0);
        go_idle();
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = 32'h0;
        hits    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (pready) hits++;
        end
        check("penable_in_idle_ignored", hits, 32'd0);
        @(posedge clk); #1;
        go_idle();

        // BaseAddress=0x1000
        dsel = 3;
        xfer(32'h0FFC, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("base_below_err", {31'b0, er}, 32'h1);
        check("base_below_rdata", rd, 32'h0);
        xfer(32'h1000, 1'b1, 32'hCAFE_0003, 1'b0, rd, er, cyc);
        check("base_wr_ok", {31'b0, er}, 32'h0);
        xfer(32'h1000, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("base_rd_data", rd, 32'hCAFE_0003);
        xfer(32'h1048, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("base_errcnt", rd, 32'h1);
        go_idle();

        // Reset asserted while a read of 0xC has pready high
        dsel = 0;
        xfer(32'h0C, 1'b1, 32'h0000_1234, 1'b0, rd, er, cyc);
        paddr   = 32'h0C;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_prdata", prdata, 32'h0000_1234);
        rst_n = 1'b0;
        #1;
        check("async_reset_pready", {31'b0, pready}, 32'h0);
        check("async_reset_prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(32'h0C, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("post_reset_word", rd, 32'h0);
        xfer(32'h40, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("post_reset_wrcnt", rd, 32'h0);
        xfer(32'h44, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("post_reset_rdcnt", rd, 32'h1);
        xfer(32'h48, 1'b0, 32'h0, 1'b0, rd, er, cyc);
        check("post_reset_errcnt", rd, 32'h0);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
